// File: rtl/debug_mem_bridge_if.sv
// Command / response / memory-port bundle between the UART command
// processor, the debug bridge and the CPU memory debug ports.
// slave  : bridge view (accepts commands, drives the memories)
// master : environment view (offers commands, models the memories)
interface debug_mem_bridge_if #(
  parameter int NUM_PORTS = 2,
  parameter int PSEL_W    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [PSEL_W-1:0]           cmd_port;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [DATA_W-1:0]           cmd_wdata;
  logic [LEN_W-1:0]            cmd_len;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [DATA_W-1:0]           rsp_data;
  logic                        rsp_err;
  logic                        rsp_last;

  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [NUM_PORTS-1:0]        mem_ce;
  logic [NUM_PORTS-1:0]        mem_we;
  logic [NUM_PORTS*DATA_W-1:0] mem_rdata;
  logic [NUM_PORTS-1:0]        mem_ready;

  modport slave (
    input  cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_wdata, cmd_len,
    input  rsp_ready, mem_rdata, mem_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last,
    output mem_addr, mem_wdata, mem_ce, mem_we
  );

  modport master (
    output cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_wdata, cmd_len,
    output rsp_ready, mem_rdata, mem_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last,
    input  mem_addr, mem_wdata, mem_ce, mem_we
  );
endinterface

// File: rtl/debug_mem_bridge.sv
// Debug-monitor to memory bridge: routes single/burst read/write commands
// to one of NUM_PORTS memory debug ports, one beat at a time, with per-beat
// ready handshake, timeout, address auto-increment and CPU-halt gating.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// ISSUE | one-cycle chip-enable (and write-enable) strobe on the port
// WAIT  | waiting for the port's ready, timeout counting down
// RESP  | beat response held until rsp_ready
// ERR   | single error response (bad port / CPU running), then IDLE
module debug_mem_bridge #(
  parameter int NUM_PORTS = 2,
  parameter int PSEL_W    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 4,
  parameter int TIMEOUT   = 255
) (
  input logic               cpu_clk,
  input logic               sys_rst,
  input logic               cpu_halt,
  debug_mem_bridge_if.slave bus
);

  // Timeout counter is loaded with TIMEOUT-1 and counts down to zero.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 write_q, write_d;
  logic [PSEL_W-1:0]    port_q, port_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_last_q, rsp_last_d;
  logic [NUM_PORTS-1:0] mem_ce_q, mem_ce_d;
  logic [NUM_PORTS-1:0] mem_we_q, mem_we_d;

  logic                 sel_ready;
  logic [DATA_W-1:0]    sel_rdata;
  logic [PSEL_W-1:0]    issue_port;
  logic [NUM_PORTS-1:0] issue_oh;
  logic                 port_ok;

  // Ready/read-data of the latched target port; other ports are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_q == PSEL_W'(p)) begin
        sel_ready = bus.mem_ready[p];
        sel_rdata = bus.mem_rdata[p*DATA_W +: DATA_W];
      end
    end
  end

  // One-hot strobe for the next ISSUE: the incoming port when leaving IDLE,
  // the latched port for later beats of a burst.
  always_comb begin
    issue_port = (state_q == S_IDLE) ? bus.cmd_port : port_q;
    issue_oh   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      issue_oh[p] = (issue_port == PSEL_W'(p));
    end
    port_ok = (int'(bus.cmd_port) < NUM_PORTS);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    write_d     = write_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;
    mem_ce_d    = '0;
    mem_we_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          write_d     = bus.cmd_write;
          port_d      = bus.cmd_port;
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
          beat_d      = bus.cmd_len;
          if (!port_ok || !cpu_halt) begin
            state_d     = S_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d  = S_ISSUE;
            mem_ce_d = issue_oh;
            mem_we_d = bus.cmd_write ? issue_oh : '0;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = TMO_W'(TIMEOUT - 1);
      end

      S_WAIT: begin
        if (sel_ready) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_last_d  = (beat_q == '0);
          rsp_data_d  = write_q ? '0 : sel_rdata;
        end else if (tmo_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_data_d  = '0;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_last_d  = 1'b0;
          rsp_data_d  = '0;
          if (rsp_err_q || rsp_last_q) begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
            beat_d = beat_q - 1'b1;
            // Halt is re-checked before every strobe; a running CPU ends the burst.
            if (!cpu_halt) begin
              state_d     = S_ERR;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_last_d  = 1'b1;
            end else begin
              state_d  = S_ISSUE;
              mem_ce_d = issue_oh;
              mem_we_d = write_q ? issue_oh : '0;
            end
          end
        end
      end

      S_ERR: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_last_d  = 1'b0;
          rsp_data_d  = '0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge cpu_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      write_q     <= 1'b0;
      port_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      mem_ce_q    <= '0;
      mem_we_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;

endmodule
